// File: rtl/uart_aes_pkg.sv
// Shared definitions for the UART <-> AES datapath: block geometry and the
// assembler state encoding, reused by the upstream TX and downstream AES stages.
package uart_aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/uart_block_assembler_if.sv
// Block hand-off bus between the UART block assembler (master) and the AES
// stage (slave): data/valid forward, ready backward.
interface uart_block_assembler_if #(
  parameter int NBYTES = uart_aes_pkg::BLOCK_BYTES
);

  logic [8*NBYTES-1:0] blk_data;
  logic                blk_valid;
  logic                blk_ready;

  modport master (output blk_data, output blk_valid, input blk_ready);
  modport slave  (input blk_data, input blk_valid, output blk_ready);

endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter: counts enabled cycles without a clear and emits a
// one-cycle expire on the TIMEOUT_CYCLES-th such cycle.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the expiry cycle suppresses the pulse.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_block_assembler.sv
// Packs UART bytes into NBYTES-wide blocks (first byte in the MSB byte) and
// hands them off over a valid/ready bus. Optional idle timeout: UART_BYTE_TIMEOUT_EN.
module uart_block_assembler
  import uart_aes_pkg::*;
#(
  parameter int NBYTES         = BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  uart_block_assembler_if.master        blk,
  output logic [4:0]                    byte_cnt,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [4:0] LAST_CNT = 5'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_block_assembler: NBYTES must be 1..32 and TIMEOUT_CYCLES >= 1");
  end

  asm_state_t   state;
  logic         handshake;
  logic         take_byte;
  logic         fills_block;
  logic [4:0]   base_cnt;
  logic [W-1:0] base_data;

  // A handshake empties the block in the same cycle, so a coincident byte
  // starts the next block from an empty base instead of being dropped.
  always_comb begin
    handshake   = (state == HOLD) && blk.blk_ready;
    take_byte   = rx_done && ((state == COLLECT) || handshake);
    base_cnt    = (state == HOLD) ? 5'd0 : byte_cnt;
    base_data   = (state == HOLD) ? '0 : blk.blk_data;
    fills_block = (base_cnt == LAST_CNT);
  end

`ifdef UART_BYTE_TIMEOUT_EN
  logic expire;

  uart_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .enable ((state == COLLECT) && (byte_cnt != 5'd0)),
    .clear  (rx_done),
    .expire (expire)
  );
`else
  assign timeout = 1'b0;
`endif

  // NOTE: the block register is a plain shift register, not a memory, so it
  // takes the async reset like the rest of the state and no stale byte survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= COLLECT;
      blk.blk_data  <= '0;
      blk.blk_valid <= 1'b0;
      byte_cnt      <= 5'd0;
      overrun       <= 1'b0;
`ifdef UART_BYTE_TIMEOUT_EN
      timeout       <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
`ifdef UART_BYTE_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (take_byte) begin
        blk.blk_data <= (base_data << 8) | W'(rx_data);
        if (fills_block) begin
          state         <= HOLD;
          blk.blk_valid <= 1'b1;
          byte_cnt      <= 5'd0;
        end else begin
          state         <= COLLECT;
          blk.blk_valid <= 1'b0;
          byte_cnt      <= base_cnt + 5'd1;
        end
      end else if (handshake) begin
        state         <= COLLECT;
        blk.blk_valid <= 1'b0;
        blk.blk_data  <= '0;
      end else if (state == HOLD) begin
        if (rx_done) begin
          overrun <= 1'b1;
        end
`ifdef UART_BYTE_TIMEOUT_EN
      end else if (expire) begin
        byte_cnt     <= 5'd0;
        blk.blk_data <= '0;
        timeout      <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/uart_block_assembler.md
UART_BLOCK_ASSEMBLER -- requirements
Module: uart_block_assembler

Interface
REQ-001 SHALL have parameter NBYTES, default 16: bytes per assembled block.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte idle limit in clk cycles, used only under REQ-024.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from the upstream UART receiver, valid only while rx_done=1.
REQ-006 SHALL have port rx_done  input  1  single-cycle strobe, one per received byte.
REQ-007 SHALL have port blk_data  output  8*NBYTES  assembled block; the first byte received occupies the MSB byte.
REQ-008 SHALL have port blk_valid  output  1  block available to the downstream AES stage.
REQ-009 SHALL have port blk_ready  input  1  downstream accepts; transfer occurs when blk_valid=1 and blk_ready=1.
REQ-010 SHALL have port byte_cnt  output  5  number of bytes held in the current partial block, 0..NBYTES-1.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a partial block is discarded.

Function
REQ-013 SHALL use states COLLECT and HOLD only.
REQ-014 In COLLECT, each rx_done SHALL shift rx_data into the block LSB byte, shift earlier bytes toward the MSB, and increment byte_cnt.
REQ-015 The rx_done that supplies byte NBYTES SHALL move the block to HOLD, clear byte_cnt to 0, and assert blk_valid on the next cycle (latency 1).
REQ-016 In HOLD, blk_data and blk_valid SHALL stay stable until the handshake completes; blk_ready SHALL have no effect when blk_valid=0.
REQ-017 On the handshake, the block SHALL return to COLLECT and deassert blk_valid on the next cycle.
REQ-018 When rx_done arrives in HOLD without a same-cycle handshake, the byte SHALL be dropped and overrun SHALL pulse for one cycle; blk_data SHALL remain unchanged.
REQ-019 When rx_done and the handshake occur in the same HOLD cycle, the byte SHALL become byte 1 of the next block (byte_cnt=1, no overrun).
REQ-020 When blk_ready is held at 1, back-to-back blocks SHALL be accepted with no byte lost.
REQ-021 Unused upper bits of blk_data SHALL never be observable; blk_data holds only valid bytes while blk_valid=1.

Reset
REQ-022 Asserting reset (low) SHALL immediately force COLLECT, blk_data=0, blk_valid=0, byte_cnt=0, overrun=0, timeout=0, and idle counter=0.
REQ-023 Reset asserted mid-block or in HOLD SHALL discard all partial or pending data; the first rx_done after release SHALL be byte 1.

Configuration
REQ-024 With macro UART_BYTE_TIMEOUT_EN defined: in COLLECT with byte_cnt>0, an idle counter SHALL count cycles without rx_done and clear on each rx_done.
REQ-025 With UART_BYTE_TIMEOUT_EN defined: when the idle counter reaches TIMEOUT_CYCLES, byte_cnt SHALL clear to 0, the partial block SHALL be discarded, and timeout SHALL pulse for one cycle.
REQ-026 With UART_BYTE_TIMEOUT_EN defined: an rx_done in the same cycle as expiry SHALL win; the counter clears and no timeout occurs.
REQ-027 Without UART_BYTE_TIMEOUT_EN: no counter logic SHALL exist, timeout SHALL be tied to 0, and a partial block SHALL wait indefinitely.

Structure
REQ-028 A shared package uart_aes_pkg SHALL hold BLOCK_BYTES (16), BLOCK_W (128), and the state encoding, for reuse by the downstream AES and upstream TX stages.
REQ-029 The idle counter SHALL be a single sub-module, uart_idle_timer (inputs: enable, clear; output: expire pulse), instantiated only under UART_BYTE_TIMEOUT_EN.

Verification
REQ-030 Sixteen bytes 0x00..0x0F with blk_ready=1 -> blk_valid asserted 1 cycle after the 16th rx_done; blk_data=0x000102030405060708090A0B0C0D0E0F; accepted the same cycle.
REQ-031 A full block with blk_ready=0, then a 17th byte 0xAB -> overrun pulses once, blk_data unchanged; raise blk_ready -> handshake completes, byte_cnt=0.
REQ-032 In HOLD, rx_done=0x55 in the same cycle as the handshake -> no overrun; byte_cnt=1; the next block's MSB byte is 0x55.
REQ-033 Reset pulled low after 7 bytes -> all outputs 0 asynchronously; 16 new bytes then form a correct block.
REQ-034 With UART_BYTE_TIMEOUT_EN and TIMEOUT_CYCLES=50: 3 bytes, then 50 idle cycles -> timeout pulses once, byte_cnt=0; a byte sent on cycle 50 instead -> no timeout, byte_cnt=4.
